instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encodes KGP_RISC instructions from separate fields into 32-bit words: opCode, functCode, reg_1, reg_2, imm and label.
- Writes each word sequentially into instruction memory. Used as the boot/test program loader ahead of the fetch stage.
- Performs the inverse of the instruction decoder's field extraction, bit-exact, and zeroes all unused bits.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- DEPTH, 1<<ADDR_W, number of words available to the loader.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse; begins a load session at base_addr
- base_addr  in  ADDR_W  first write address, sampled on start
- in_valid  in  1  field bundle valid
- in_ready  out  1  loader can accept a bundle
- in_last  in  1  bundle is the final instruction of the session
- opCode  in  3  instruction class
- functCode  in  4  function code
- reg_1  in  5  first register field
- reg_2  in  5  second register field
- imm  in  15  immediate
- label  in  15  branch target
- imem_we  out  1  memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded instruction
- busy  out  1  session active
- done  out  1  one-cycle pulse at session end
- err_illegal  out  1  sticky: an opCode 110 or 111 was received
- err_overflow  out  1  sticky: address space exhausted
- word_count  out  ADDR_W+1  words written this session

Behaviour:
- Encoding (all opcodes): [31:29]=opCode, [3:0]=functCode; every bit not listed below is 0.
  - 000: [28:24]=reg_1, [23:19]=reg_2.
  - 001: [28:24]=reg_1, [23:9]=imm.
  - 010: [28:24]=reg_1, [23:19]=reg_2, [18:4]=imm.
  - 011: [28:14]=label.
  - 100: [28:24]=reg_1.
  - 101: [28:24]=reg_1, [23:9]=label.
  - 110/111: illegal; no word is written.
- Reset (rst_n low at a clock edge): state IDLE, and every output is 0 (in_ready, imem_we, imem_addr, imem_wdata, busy, done, both err flags, word_count). This holds even mid-session; a pending write is dropped.
- FSM states:
  - IDLE: in_ready=0. On start, latch base_addr into the address pointer, clear word_count and both err flags, go to ACCEPT.
  - ACCEPT: in_ready=1, busy=1. A handshake (in_valid & in_ready) registers the encoded word, and in_last, then goes to WRITE.
    - Illegal opcode: set err_illegal, no write. If in_last, go to FIN; otherwise stay in ACCEPT.
  - WRITE: imem_we=1 for exactly one cycle with the registered address and data. Then increment the pointer and word_count.
    - Next state is FIN if in_last was set, or if the pointer was DEPTH-1 (the latter also sets err_overflow). Otherwise ACCEPT.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- Throughput and latency:
  - At most one bundle per 2 cycles; in_ready is low in WRITE and FIN.
  - Latency from handshake to imem_we is 1 cycle.
- Address pointer:
  - Never wraps. Overflow terminates the session; later bundles are not accepted until the next start.
- Timing and hold rules:
  - start is ignored outside IDLE.
  - in_valid in IDLE is ignored and the bundle is not consumed.
  - err flags and word_count hold their values after FIN until the next start.
- imem_wdata and imem_addr hold their last values when imem_we=0.

Decomposition:
- Shared package kgp_risc_pkg holds:
  - opcode constants OP_RR=000, OP_RI=001, OP_RRI=010, OP_J=011, OP_R=100, OP_RL=101;
  - field bit-position constants;
  - the FSM state encoding.
- One combinational sub-module, instr_packer: fields to a 32-bit word plus an illegal flag. It is reused by the assembler-side testbench.

Test Plan:
- 010, reg_1=3, reg_2=5, imm=0x0012, funct=2, base 0, in_last=1:
  - one write, addr 0, data 0x43280122;
  - done pulse the following cycle;
  - word_count=1.
- 011, label=0x7FFF, funct=0, at base 0x10: data 0x7FFFC000, addr 0x10. Also check the other field inputs are ignored (driven to 0x1F/0x7FFF).
- Burst of 3 bundles with in_valid held high, the third marked last:
  - the first is 001, reg_1=31, imm=0x4000, funct=1, written as 0x3F800001;
  - check writes at addresses b, b+1, b+2, spaced 2 cycles apart, with in_ready low during WRITE.
- Opcode 110 mid-burst: no imem_we for that bundle, err_illegal=1 until the next start, and remaining bundles are still written.
- base_addr=DEPTH-1 with 2 bundles:
  - the first is written at DEPTH-1;
  - then err_overflow=1 and a done pulse;
  - the second bundle is not accepted and word_count=1.
- rst_n low during WRITE: imem_we=0 at the next edge and all outputs are 0. A fresh start afterwards works normally.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// Shared KGP_RISC definitions: opcode values, instruction field positions
// and the loader FSM state encoding.
package kgp_risc_pkg;

    localparam logic [2:0] OP_RR  = 3'b000;
    localparam logic [2:0] OP_RI  = 3'b001;
    localparam logic [2:0] OP_RRI = 3'b010;
    localparam logic [2:0] OP_J   = 3'b011;
    localparam logic [2:0] OP_R   = 3'b100;
    localparam logic [2:0] OP_RL  = 3'b101;

    // Least-significant bit of each field inside the 32-bit word
    localparam int OP_LSB      = 29;
    localparam int R1_LSB      = 24;
    localparam int R2_LSB      = 19;
    localparam int IMM_RI_LSB  = 9;
    localparam int IMM_RRI_LSB = 4;
    localparam int LBL_J_LSB   = 14;
    localparam int LBL_RL_LSB  = 9;
    localparam int FN_LSB      = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FIN    = 2'd3
    } state_e;

endpackage

// File: rtl/instr_packer.sv
// Combinational KGP_RISC field packer: builds the 32-bit instruction word
// from its fields (inverse of the decoder) and flags illegal opcodes.
module instr_packer
    import kgp_risc_pkg::*;
(
    input  logic [2:0]  op_code,
    input  logic [3:0]  funct_code,
    input  logic [4:0]  reg_1,
    input  logic [4:0]  reg_2,
    input  logic [14:0] imm,
    input  logic [14:0] label,
    output logic [31:0] word,
    output logic        illegal
);

    // Place only the fields the opcode uses; every other bit stays zero
    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        word[OP_LSB +: 3] = op_code;
        word[FN_LSB +: 4] = funct_code;
        case (op_code)
            OP_RR: begin
                word[R1_LSB +: 5] = reg_1;
                word[R2_LSB +: 5] = reg_2;
            end
            OP_RI: begin
                word[R1_LSB +: 5]      = reg_1;
                word[IMM_RI_LSB +: 15] = imm;
            end
            OP_RRI: begin
                word[R1_LSB +: 5]       = reg_1;
                word[R2_LSB +: 5]       = reg_2;
                word[IMM_RRI_LSB +: 15] = imm;
            end
            OP_J: begin
                word[LBL_J_LSB +: 15] = label;
            end
            OP_R: begin
                word[R1_LSB +: 5] = reg_1;
            end
            OP_RL: begin
                word[R1_LSB +: 5]      = reg_1;
                word[LBL_RL_LSB +: 15] = label;
            end
            default: begin
                word    = 32'h0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot/test program loader: accepts instruction field bundles, encodes them
// and writes them one per two cycles into instruction memory from base_addr.
module instr_encoder_loader
    import kgp_risc_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        opCode,
    input  logic [3:0]        functCode,
    input  logic [4:0]        reg_1,
    input  logic [4:0]        reg_2,
    input  logic [14:0]       imm,
    input  logic [14:0]       label,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    // Last usable address; the pointer stops here instead of wrapping
    localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic              err_ill_q, err_ill_d;
    logic              err_ovf_q, err_ovf_d;

    logic [31:0]       pk_word;
    logic              pk_illegal;

    instr_packer u_packer (
        .op_code    (opCode),
        .funct_code (functCode),
        .reg_1      (reg_1),
        .reg_2      (reg_2),
        .imm        (imm),
        .label      (label),
        .word       (pk_word),
        .illegal    (pk_illegal)
    );

    // Outputs decoded directly from the state; the write port holds its
    // registered address/data between writes
    assign in_ready     = (state_q == ST_ACCEPT);
    assign busy         = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
    assign imem_we      = (state_q == ST_WRITE);
    assign done         = (state_q == ST_FIN);
    assign imem_addr    = waddr_q;
    assign imem_wdata   = wdata_q;
    assign err_illegal  = err_ill_q;
    assign err_overflow = err_ovf_q;
    assign word_count   = cnt_q;

    // Next-state logic: session start, bundle capture, write bookkeeping
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        last_d    = last_q;
        err_ill_d = err_ill_q;
        err_ovf_d = err_ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d     = base_addr;
                    cnt_d     = '0;
                    err_ill_d = 1'b0;
                    err_ovf_d = 1'b0;
                    state_d   = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (in_valid) begin
                    if (pk_illegal) begin
                        // Dropped bundle: no write, session continues unless last
                        err_ill_d = 1'b1;
                        if (in_last) begin
                            state_d = ST_FIN;
                        end
                    end else begin
                        waddr_d = ptr_q;
                        wdata_d = pk_word;
                        last_d  = in_last;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_q + 1'b1;
                if (ptr_q == PTR_MAX) begin
                    err_ovf_d = 1'b1;
                    state_d   = ST_FIN;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = last_q ? ST_FIN : ST_ACCEPT;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything visible
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            last_q    <= 1'b0;
            err_ill_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            last_q    <= last_d;
            err_ill_q <= err_ill_d;
            err_ovf_q <= err_ovf_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: table of single-instruction
// sessions plus hand-written burst, illegal, overflow and reset sequences.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        opCode;
    logic [3:0]        functCode;
    logic [4:0]        reg_1;
    logic [4:0]        reg_2;
    logic [14:0]       imm;
    logic [14:0]       label;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err_illegal;
    logic              err_overflow;
    logic [ADDR_W:0]   word_count;

    instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .opCode       (opCode),
        .functCode    (functCode),
        .reg_1        (reg_1),
        .reg_2        (reg_2),
        .imm          (imm),
        .label        (label),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .busy         (busy),
        .done         (done),
        .err_illegal  (err_illegal),
        .err_overflow (err_overflow),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  fn;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [14:0] imm;
        logic [14:0] lbl;
        logic        last;
    } bundle_t;

    typedef struct {
        bundle_t     b;
        logic [9:0]  base;
        logic        ill;
        logic [31:0] exp;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    bundle_t     bq[8];
    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          done_cyc;
    int          consumed;
    vec_t        vecs[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [2:0] op, input logic [3:0] fn,
                                   input logic [4:0] r1, input logic [4:0] r2,
                                   input logic [14:0] im, input logic [14:0] lb,
                                   input logic last);
        bundle_t b;
        b.op = op; b.fn = fn; b.r1 = r1; b.r2 = r2; b.imm = im; b.lbl = lb; b.last = last;
        return b;
    endfunction

    task automatic drive(input bundle_t b);
        opCode    = b.op;
        functCode = b.fn;
        reg_1     = b.r1;
        reg_2     = b.r2;
        imm       = b.imm;
        label     = b.lbl;
        in_last   = b.last;
    endtask

    // Start a session at b and stream bq[0..n-1] with in_valid held high,
    // logging every write until the done pulse (bounded).
    task automatic burst(input int n, input logic [9:0] b);
        int   cyc;
        int   idx;
        logic seen;
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        idx = 0;
        cyc = 0;
        seen = 1'b0;
        done_cyc = -1;
        while (!seen && cyc < 40) begin
            if (imem_we) begin
                wa_q.push_back(imem_addr);
                wd_q.push_back(imem_wdata);
                wc_q.push_back(cyc);
                chk("ready_low_in_write", {63'd0, in_ready}, 64'd0);
            end
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end else begin
                if (idx < n) begin
                    drive(bq[idx]);
                    in_valid = 1'b1;
                    if (in_ready) idx++;
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0;
        consumed = idx;
        chk("done_seen", {63'd0, seen}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        drive(mk(3'd0, 4'd0, 5'd0, 5'd0, 15'd0, 15'd0, 1'b0));

        vecs[0] = '{mk(3'b010, 4'd2,  5'd3,  5'd5,  15'h0012, 15'h0000, 1'b1), 10'h000, 1'b0, 32'h43280122};
        vecs[1] = '{mk(3'b011, 4'd0,  5'h1F, 5'h1F, 15'h7FFF, 15'h7FFF, 1'b1), 10'h010, 1'b0, 32'h7FFFC000};
        vecs[2] = '{mk(3'b000, 4'd3,  5'd1,  5'd2,  15'h7FFF, 15'h7FFF, 1'b1), 10'h020, 1'b0, 32'h01100003};
        vecs[3] = '{mk(3'b001, 4'd1,  5'd31, 5'h1F, 15'h4000, 15'h7FFF, 1'b1), 10'h030, 1'b0, 32'h3F800001};
        vecs[4] = '{mk(3'b100, 4'd5,  5'd7,  5'h1F, 15'h7FFF, 15'h7FFF, 1'b1), 10'h040, 1'b0, 32'h87000005};
        vecs[5] = '{mk(3'b101, 4'd6,  5'd2,  5'h1F, 15'h7FFF, 15'h1234, 1'b1), 10'h050, 1'b0, 32'hA2246806};
        vecs[6] = '{mk(3'b111, 4'hF,  5'h1F, 5'h1F, 15'h7FFF, 15'h7FFF, 1'b1), 10'h060, 1'b1, 32'h00000000};
        vecs[7] = '{mk(3'b010, 4'hF,  5'h1F, 5'h1F, 15'h7FFF, 15'h7FFF, 1'b1), 10'h070, 1'b0, 32'h5FFFFFFF};
        vecs[8] = '{mk(3'b101, 4'hF,  5'h1F, 5'h1F, 15'h7FFF, 15'h7FFF, 1'b1), 10'h080, 1'b0, 32'hBFFFFE0F};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {5'd0, in_ready, imem_we, imem_addr, imem_wdata, busy, done,
                              err_illegal, err_overflow, word_count}, 64'd0);
        rst_n = 1'b1;

        // Single-instruction sessions from the table
        foreach (vecs[i]) begin
            bq[0] = vecs[i].b;
            burst(1, vecs[i].base);
            chk($sformatf("v%0d_nwrites", i), 64'(wa_q.size()), vecs[i].ill ? 64'd0 : 64'd1);
            if (!vecs[i].ill && wa_q.size() == 1) begin
                chk($sformatf("v%0d_addr", i), 64'(wa_q[0]), 64'(vecs[i].base));
                chk($sformatf("v%0d_data", i), 64'(wd_q[0]), 64'(vecs[i].exp));
                chk($sformatf("v%0d_done_lat", i), 64'(done_cyc), 64'(wc_q[0] + 1));
            end
            chk($sformatf("v%0d_busy_fin", i), {63'd0, busy}, 64'd0);
            chk($sformatf("v%0d_wcount", i), 64'(word_count), vecs[i].ill ? 64'd0 : 64'd1);
            chk($sformatf("v%0d_err_ill", i), {63'd0, err_illegal}, {63'd0, vecs[i].ill});
        end

        // Burst of three with in_valid held high
        bq[0] = mk(3'b001, 4'd1, 5'd31, 5'd0, 15'h4000, 15'd0, 1'b0);
        bq[1] = mk(3'b000, 4'd3, 5'd1,  5'd2, 15'd0,    15'd0, 1'b0);
        bq[2] = mk(3'b100, 4'd5, 5'd7,  5'd0, 15'd0,    15'd0, 1'b1);
        burst(3, 10'h100);
        chk("burst_nwrites", 64'(wa_q.size()), 64'd3);
        if (wa_q.size() == 3) begin
            chk("burst_addr0", 64'(wa_q[0]), 64'h100);
            chk("burst_addr1", 64'(wa_q[1]), 64'h101);
            chk("burst_addr2", 64'(wa_q[2]), 64'h102);
            chk("burst_data0", 64'(wd_q[0]), 64'h3F800001);
            chk("burst_data1", 64'(wd_q[1]), 64'h01100003);
            chk("burst_data2", 64'(wd_q[2]), 64'h87000005);
            chk("burst_gap01", 64'(wc_q[1] - wc_q[0]), 64'd2);
            chk("burst_gap12", 64'(wc_q[2] - wc_q[1]), 64'd2);
            chk("burst_done_lat", 64'(done_cyc), 64'(wc_q[2] + 1));
        end
        chk("burst_wcount", 64'(word_count), 64'd3);

        // Illegal opcode in the middle of a burst
        bq[0] = mk(3'b000, 4'd3, 5'd1,  5'd2, 15'd0,    15'd0, 1'b0);
        bq[1] = mk(3'b110, 4'd9, 5'd4,  5'd4, 15'h1111, 15'd0, 1'b0);
        bq[2] = mk(3'b001, 4'd1, 5'd31, 5'd0, 15'h4000, 15'd0, 1'b1);
        burst(3, 10'h200);
        chk("ill_nwrites", 64'(wa_q.size()), 64'd2);
        if (wa_q.size() == 2) begin
            chk("ill_addr0", 64'(wa_q[0]), 64'h200);
            chk("ill_addr1", 64'(wa_q[1]), 64'h201);
            chk("ill_data1", 64'(wd_q[1]), 64'h3F800001);
        end
        chk("ill_flag", {63'd0, err_illegal}, 64'd1);
        chk("ill_wcount", 64'(word_count), 64'd2);
        repeat (3) @(negedge clk);
        chk("ill_flag_hold", {63'd0, err_illegal}, 64'd1);
        chk("ill_hold_addr", 64'(imem_addr), 64'h201);
        chk("ill_hold_data", 64'(imem_wdata), 64'h3F800001);

        // Address space exhausted at DEPTH-1
        bq[0] = mk(3'b000, 4'd1, 5'd1, 5'd1, 15'd0, 15'd0, 1'b0);
        bq[1] = mk(3'b000, 4'd2, 5'd2, 5'd2, 15'd0, 15'd0, 1'b1);
        burst(2, 10'h3FF);
        chk("ovf_nwrites", 64'(wa_q.size()), 64'd1);
        if (wa_q.size() == 1) begin
            chk("ovf_addr", 64'(wa_q[0]), 64'h3FF);
            chk("ovf_done_lat", 64'(done_cyc), 64'(wc_q[0] + 1));
        end
        chk("ovf_consumed", 64'(consumed), 64'd1);
        chk("ovf_flag", {63'd0, err_overflow}, 64'd1);
        chk("ovf_ill_cleared", {63'd0, err_illegal}, 64'd0);
        chk("ovf_wcount", 64'(word_count), 64'd1);
        drive(bq[1]);
        in_valid = 1'b1;
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (imem_we || in_ready) bad++;
            end
            chk("ovf_no_accept", 64'(bad), 64'd0);
        end
        in_valid = 1'b0;
        chk("ovf_flag_hold", {63'd0, err_overflow}, 64'd1);

        // Reset asserted while a write is in progress
        @(negedge clk);
        start = 1'b1;
        base_addr = 10'h300;
        @(negedge clk);
        start = 1'b0;
        drive(mk(3'b010, 4'd2, 5'd3, 5'd5, 15'h0012, 15'd0, 1'b1));
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_in_write_we", {63'd0, imem_we}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", {5'd0, in_ready, imem_we, imem_addr, imem_wdata, busy, done,
                                err_illegal, err_overflow, word_count}, 64'd0);
        rst_n = 1'b1;
        bq[0] = mk(3'b011, 4'd0, 5'd0, 5'd0, 15'd0, 15'h7FFF, 1'b1);
        burst(1, 10'h301);
        chk("rst_fresh_nwrites", 64'(wa_q.size()), 64'd1);
        if (wa_q.size() == 1) begin
            chk("rst_fresh_addr", 64'(wa_q[0]), 64'h301);
            chk("rst_fresh_data", 64'(wd_q[0]), 64'h7FFFC000);
        end
        chk("rst_fresh_wcount", 64'(word_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
